// File: rtl/hub75_row_shifter_if.sv
// hub75_row_shifter_if: frame buffer read port between the row shifter (master) and memory (slave).
interface hub75_row_shifter_if #(
  parameter int addr_width_p = 12,
  parameter int data_width_p = 48
);
  logic                    rd;
  logic [addr_width_p-1:0] addr;
  logic [data_width_p-1:0] rdata;
  modport master (output rd, addr, input rdata);
  modport slave (input rd, addr, output rdata);
endinterface

// File: rtl/hub75_row_shifter.sv
// hub75_row_shifter: fetches one row of pixel words and shifts the selected bit plane onto HUB75 RGB lines.
module hub75_row_shifter #(
  parameter int hpixel_p     = 64,
  parameter int vpixel_p     = 64,
  parameter int bpp_p        = 8,
  parameter int segments_p   = 2,
  parameter int clk_div_wd_p = 8,
  parameter int addr_width_p = $clog2(hpixel_p*vpixel_p),
  parameter int pix_bit_wd_p = $clog2(bpp_p)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [clk_div_wd_p-1:0]   i_clk_div,
  input  logic                      i_tx_start,
  input  logic [addr_width_p-1:0]   i_init_addr,
  input  logic [pix_bit_wd_p-1:0]   i_pix_bit,
  output logic                      o_tx_ready,
  output logic                      o_line_done,
  hub75_row_shifter_if.master       mem,
  output logic [segments_p*3-1:0]   o_rgb,
  output logic                      o_sclk
);
  localparam int ch_p = segments_p*3;
  localparam int col_wd_p = hpixel_p > 1 ? $clog2(hpixel_p) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, LOW, HIGH} state_t;
  state_t state, state_n;
  logic [clk_div_wd_p-1:0] cnt, cnt_n, d, d_n;
  logic [col_wd_p-1:0] col, col_n;
  logic [pix_bit_wd_p-1:0] pb, pb_n;
  logic [ch_p-1:0] pre, pre_n, bits, rgb_n;
  logic ready_n, done_n, sclk_n, rd_n, last_col, more_rd;
  logic [addr_width_p-1:0] addr_n;
  for (genvar g = 0; g < ch_p; g++) begin : g_bit
    logic [bpp_p-1:0] fld;
    assign fld = mem.rdata[g*bpp_p +: bpp_p];
    assign bits[g] = fld[pb];
  end
  assign last_col = int'(col) == hpixel_p-1;
  assign more_rd = int'(col) + 2 < hpixel_p;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    d_n = d;
    col_n = col;
    pb_n = pb;
    pre_n = pre;
    rgb_n = o_rgb;
    sclk_n = o_sclk;
    ready_n = o_tx_ready;
    done_n = 1'b0;
    case (state)
      IDLE: if (i_tx_start) begin
        state_n = FETCH;
        d_n = i_clk_div;
        pb_n = i_pix_bit;
        ready_n = 1'b0;
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        state_n = LOW;
        rgb_n = bits;
        cnt_n = '0;
        col_n = '0;
      end
      LOW: begin
        pre_n = cnt == '0 ? bits : pre;
        if (cnt == d) begin
          state_n = HIGH;
          cnt_n = '0;
          sclk_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      HIGH: if (cnt == d) begin
        cnt_n = '0;
        sclk_n = 1'b0;
        if (last_col) begin
          state_n = IDLE;
          ready_n = 1'b1;
          done_n = 1'b1;
        end else begin
          state_n = LOW;
          rgb_n = pre;
          col_n = col + 1'b1;
        end
      end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
    // reads land in the last HIGH cycle so the data arrives in the first LOW cycle of the next column
    rd_n = state_n == FETCH || (state_n == LOAD && hpixel_p > 1) || (state_n == HIGH && cnt_n == d && more_rd);
    addr_n = state_n == FETCH ? i_init_addr : rd_n ? mem.addr + 1'b1 : mem.addr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      d <= '0;
      col <= '0;
      pb <= '0;
      pre <= '0;
      o_rgb <= '0;
      o_sclk <= 1'b0;
      o_tx_ready <= 1'b1;
      o_line_done <= 1'b0;
      mem.rd <= 1'b0;
      mem.addr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      d <= d_n;
      col <= col_n;
      pb <= pb_n;
      pre <= pre_n;
      o_rgb <= rgb_n;
      o_sclk <= sclk_n;
      o_tx_ready <= ready_n;
      o_line_done <= done_n;
      mem.rd <= rd_n;
      mem.addr <= addr_n;
    end
endmodule

// File: tb/tb_hub75_row_shifter.sv
// tb_hub75_row_shifter: directed checks of row fetch, bit-plane serialisation, timing and reset.
module tb_hub75_row_shifter;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [7:0] clk_div = 0;
  logic tx_start = 0;
  logic [11:0] init_addr = 0;
  logic [2:0] pix_bit = 0;
  logic tx_ready, line_done, sclk;
  logic [5:0] rgb;
  int vecs = 0, errs = 0;
  hub75_row_shifter_if #(.addr_width_p(12), .data_width_p(48)) mem ();
  hub75_row_shifter dut (
    .clk(clk), .rst_n(rst_n), .i_clk_div(clk_div), .i_tx_start(tx_start),
    .i_init_addr(init_addr), .i_pix_bit(pix_bit), .o_tx_ready(tx_ready),
    .o_line_done(line_done), .mem(mem), .o_rgb(rgb), .o_sclk(sclk)
  );
  function automatic logic [47:0] word(input logic [11:0] a);
    return {a, ~a, a[5:0], a[11:6], a ^ 12'h5A3};
  endfunction
  function automatic logic [5:0] exp_rgb(input logic [11:0] a, input logic [2:0] pb);
    logic [47:0] w = word(a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = w[i*8 + int'(pb)];
    return r;
  endfunction
  // memory answers one cycle after a read strobe; otherwise it drives junk
  always @(posedge clk) mem.rdata <= mem.rd ? word(mem.addr) : (48'hA5A5_0F0F_3C3C ^ {4{mem.addr}});
  logic [11:0] rd_q[$];
  logic [5:0] rise_q[$];
  int hi_q[$], lo_q[$];
  int done_cnt = 0, busy_cnt = 0, run = 0;
  logic prev_sclk = 0;
  always @(negedge clk)
    if (!rst_n) begin
      prev_sclk = 0;
      run = 0;
    end else begin
      if (mem.rd) rd_q.push_back(mem.addr);
      if (line_done) done_cnt++;
      if (!tx_ready) busy_cnt++;
      if (sclk && !prev_sclk) rise_q.push_back(rgb);
      if (sclk == prev_sclk) run++;
      else begin
        if (prev_sclk) hi_q.push_back(run);
        else lo_q.push_back(run);
        run = 1;
      end
      prev_sclk = sclk;
    end
  int rb, qb, hb, lb, db, bb;
  task automatic snap();
    rb = rd_q.size(); qb = rise_q.size(); hb = hi_q.size(); lb = lo_q.size();
    db = done_cnt; bb = busy_cnt;
  endtask
  task automatic do_row(input logic [11:0] a, input logic [2:0] pb, input logic [7:0] dv, input int hold, output bit ok);
    @(negedge clk);
    tx_start = 1; init_addr = a; pix_bit = pb; clk_div = dv;
    repeat (hold) @(negedge clk);
    tx_start = 0;
    ok = 0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(negedge clk);
      if (line_done) ok = 1;
    end
    @(negedge clk);
  endtask
  task automatic wait_done(output bit ok);
    ok = 0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(negedge clk);
      if (line_done) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    vecs++; if (tx_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b exp 1", tx_ready); end
    vecs++; if (line_done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b exp 0", line_done); end
    vecs++; if (mem.rd !== 1'b0) begin errs++; $display("FAIL reset_rd: got %b exp 0", mem.rd); end
    vecs++; if (mem.addr !== 12'h0) begin errs++; $display("FAIL reset_addr: got %h exp 000", mem.addr); end
    vecs++; if (rgb !== 6'h0) begin errs++; $display("FAIL reset_rgb: got %h exp 00", rgb); end
    vecs++; if (sclk !== 1'b0) begin errs++; $display("FAIL reset_sclk: got %b exp 0", sclk); end
    rst_n = 1;
    repeat (2) @(negedge clk);
    vecs++; if (tx_ready !== 1'b1 || mem.rd !== 1'b0) begin errs++; $display("FAIL idle_after_reset: ready %b rd %b exp 1 0", tx_ready, mem.rd); end
  endtask

  task automatic test_basic();
    bit ok;
    snap();
    do_row(12'h040, 3'd3, 8'd0, 1, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL basic_timeout: no line_done"); end
    vecs++; if (busy_cnt - bb != 130) begin errs++; $display("FAIL basic_busy: got %0d exp 130", busy_cnt - bb); end
    vecs++; if (rise_q.size() - qb != 64) begin errs++; $display("FAIL basic_rises: got %0d exp 64", rise_q.size() - qb); end
    vecs++; if (done_cnt - db != 1) begin errs++; $display("FAIL basic_done: got %0d exp 1", done_cnt - db); end
    vecs++; if (rd_q.size() - rb != 64) begin errs++; $display("FAIL basic_reads: got %0d exp 64", rd_q.size() - rb); end
    for (int i = 0; i < 64 && rb + i < rd_q.size(); i++) begin
      vecs++; if (rd_q[rb+i] !== 12'(12'h040 + i)) begin errs++; $display("FAIL basic_addr[%0d]: got %h exp %h", i, rd_q[rb+i], 12'(12'h040 + i)); end
    end
    for (int i = 0; i < 64 && qb + i < rise_q.size(); i++) begin
      vecs++; if (rise_q[qb+i] !== exp_rgb(12'(12'h040 + i), 3'd3)) begin errs++; $display("FAIL basic_rgb[%0d]: got %h exp %h", i, rise_q[qb+i], exp_rgb(12'(12'h040 + i), 3'd3)); end
    end
  endtask

  task automatic test_bitplanes();
    bit ok;
    logic [11:0] a;
    for (int p = 0; p < 8; p++) begin
      a = 12'(12'h100 + p*83);
      snap();
      do_row(a, 3'(p), 8'd0, 1, ok);
      vecs++; if (!ok || rise_q.size() - qb != 64) begin errs++; $display("FAIL plane%0d_rises: got %0d exp 64", p, rise_q.size() - qb); end
      for (int i = 0; i < 64 && qb + i < rise_q.size(); i++) begin
        vecs++; if (rise_q[qb+i] !== exp_rgb(12'(a + i), 3'(p))) begin errs++; $display("FAIL plane%0d_rgb[%0d]: got %h exp %h", p, i, rise_q[qb+i], exp_rgb(12'(a + i), 3'(p))); end
      end
    end
  endtask

  task automatic test_clk_div();
    bit ok;
    snap();
    @(negedge clk);
    tx_start = 1; init_addr = 12'h7C0; pix_bit = 3'd5; clk_div = 8'd3;
    @(negedge clk);
    tx_start = 0;
    repeat (20) @(negedge clk);
    clk_div = 8'd0;
    wait_done(ok);
    @(negedge clk);
    vecs++; if (!ok) begin errs++; $display("FAIL div_timeout: no line_done"); end
    vecs++; if (busy_cnt - bb != 514) begin errs++; $display("FAIL div_busy: got %0d exp 514", busy_cnt - bb); end
    vecs++; if (hi_q.size() - hb != 64 || lo_q.size() - lb != 64) begin errs++; $display("FAIL div_runs: got hi %0d lo %0d exp 64 64", hi_q.size() - hb, lo_q.size() - lb); end
    for (int i = 0; i < 64 && hb + i < hi_q.size(); i++) begin
      vecs++; if (hi_q[hb+i] != 4) begin errs++; $display("FAIL div_high[%0d]: got %0d exp 4", i, hi_q[hb+i]); end
    end
    for (int i = 1; i < 64 && lb + i < lo_q.size(); i++) begin
      vecs++; if (lo_q[lb+i] != 4) begin errs++; $display("FAIL div_low[%0d]: got %0d exp 4", i, lo_q[lb+i]); end
    end
    for (int i = 0; i < 64 && qb + i < rise_q.size(); i++) begin
      vecs++; if (rise_q[qb+i] !== exp_rgb(12'(12'h7C0 + i), 3'd5)) begin errs++; $display("FAIL div_rgb[%0d]: got %h exp %h", i, rise_q[qb+i], exp_rgb(12'(12'h7C0 + i), 3'd5)); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    snap();
    do_row(12'hFFE, 3'd6, 8'd0, 1, ok);
    vecs++; if (!ok || rd_q.size() - rb != 64) begin errs++; $display("FAIL wrap_reads: got %0d exp 64", rd_q.size() - rb); end
    for (int i = 0; i < 64 && rb + i < rd_q.size(); i++) begin
      vecs++; if (rd_q[rb+i] !== 12'(12'hFFE + i)) begin errs++; $display("FAIL wrap_addr[%0d]: got %h exp %h", i, rd_q[rb+i], 12'(12'hFFE + i)); end
    end
    for (int i = 0; i < 64 && qb + i < rise_q.size(); i++) begin
      vecs++; if (rise_q[qb+i] !== exp_rgb(12'(12'hFFE + i), 3'd6)) begin errs++; $display("FAIL wrap_rgb[%0d]: got %h exp %h", i, rise_q[qb+i], exp_rgb(12'(12'hFFE + i), 3'd6)); end
    end
  endtask

  task automatic test_ignore_start();
    bit ok;
    snap();
    do_row(12'h200, 3'd1, 8'd0, 3, ok);
    repeat (5) @(negedge clk);
    vecs++; if (!ok || done_cnt - db != 1 || busy_cnt - bb != 130) begin errs++; $display("FAIL held_start: got done %0d busy %0d exp 1 130", done_cnt - db, busy_cnt - bb); end
    snap();
    @(negedge clk);
    tx_start = 1; init_addr = 12'h300; pix_bit = 3'd0;
    @(negedge clk);
    tx_start = 0;
    repeat (30) @(negedge clk);
    tx_start = 1; init_addr = 12'h555; pix_bit = 3'd7;
    @(negedge clk);
    tx_start = 0;
    wait_done(ok);
    repeat (5) @(negedge clk);
    vecs++; if (!ok || done_cnt - db != 1 || busy_cnt - bb != 130) begin errs++; $display("FAIL busy_start: got done %0d busy %0d exp 1 130", done_cnt - db, busy_cnt - bb); end
    vecs++; if (rd_q.size() - rb != 64) begin errs++; $display("FAIL busy_reads: got %0d exp 64", rd_q.size() - rb); end
    for (int i = 0; i < 64 && rb + i < rd_q.size(); i++) begin
      vecs++; if (rd_q[rb+i] !== 12'(12'h300 + i)) begin errs++; $display("FAIL busy_addr[%0d]: got %h exp %h", i, rd_q[rb+i], 12'(12'h300 + i)); end
    end
    for (int i = 0; i < 64 && qb + i < rise_q.size(); i++) begin
      vecs++; if (rise_q[qb+i] !== exp_rgb(12'(12'h300 + i), 3'd0)) begin errs++; $display("FAIL busy_rgb[%0d]: got %h exp %h", i, rise_q[qb+i], exp_rgb(12'(12'h300 + i), 3'd0)); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    snap();
    @(negedge clk);
    tx_start = 1; init_addr = 12'h0A0; pix_bit = 3'd2; clk_div = 8'd0;
    @(negedge clk);
    tx_start = 0;
    wait_done(ok1);
    tx_start = 1; init_addr = 12'h0C0; pix_bit = 3'd4;
    @(negedge clk);
    tx_start = 0;
    vecs++; if (tx_ready !== 1'b0) begin errs++; $display("FAIL b2b_gap: ready got %b exp 0", tx_ready); end
    wait_done(ok2);
    @(negedge clk);
    vecs++; if (!ok1 || !ok2 || done_cnt - db != 2) begin errs++; $display("FAIL b2b_done: got %0d exp 2", done_cnt - db); end
    vecs++; if (busy_cnt - bb != 260) begin errs++; $display("FAIL b2b_busy: got %0d exp 260", busy_cnt - bb); end
    vecs++; if (rd_q.size() - rb != 128 || rise_q.size() - qb != 128) begin errs++; $display("FAIL b2b_counts: got reads %0d rises %0d exp 128 128", rd_q.size() - rb, rise_q.size() - qb); end
    for (int i = 0; i < 128 && rb + i < rd_q.size(); i++) begin
      vecs++; if (rd_q[rb+i] !== 12'((i < 64 ? 12'h0A0 : 12'h080) + i)) begin errs++; $display("FAIL b2b_addr[%0d]: got %h exp %h", i, rd_q[rb+i], 12'((i < 64 ? 12'h0A0 : 12'h080) + i)); end
    end
    for (int i = 0; i < 128 && qb + i < rise_q.size(); i++) begin
      vecs++; if (rise_q[qb+i] !== exp_rgb(12'((i < 64 ? 12'h0A0 : 12'h080) + i), i < 64 ? 3'd2 : 3'd4)) begin errs++; $display("FAIL b2b_rgb[%0d]: got %h exp %h", i, rise_q[qb+i], exp_rgb(12'((i < 64 ? 12'h0A0 : 12'h080) + i), i < 64 ? 3'd2 : 3'd4)); end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    @(negedge clk);
    tx_start = 1; init_addr = 12'h321; pix_bit = 3'd7; clk_div = 8'd1;
    @(negedge clk);
    tx_start = 0;
    repeat (50) @(negedge clk);
    #2 rst_n = 0;
    #1;
    vecs++; if (tx_ready !== 1'b1 || line_done !== 1'b0) begin errs++; $display("FAIL arst_ctrl: ready %b done %b exp 1 0", tx_ready, line_done); end
    vecs++; if (mem.rd !== 1'b0 || mem.addr !== 12'h0) begin errs++; $display("FAIL arst_mem: rd %b addr %h exp 0 000", mem.rd, mem.addr); end
    vecs++; if (rgb !== 6'h0 || sclk !== 1'b0) begin errs++; $display("FAIL arst_out: rgb %h sclk %b exp 00 0", rgb, sclk); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    snap();
    do_row(12'h321, 3'd7, 8'd1, 1, ok);
    vecs++; if (!ok || done_cnt - db != 1) begin errs++; $display("FAIL arst_done: got %0d exp 1", done_cnt - db); end
    vecs++; if (busy_cnt - bb != 258) begin errs++; $display("FAIL arst_busy: got %0d exp 258", busy_cnt - bb); end
    vecs++; if (rd_q.size() - rb != 64 || rise_q.size() - qb != 64) begin errs++; $display("FAIL arst_counts: got reads %0d rises %0d exp 64 64", rd_q.size() - rb, rise_q.size() - qb); end
    for (int i = 0; i < 64 && rb + i < rd_q.size(); i++) begin
      vecs++; if (rd_q[rb+i] !== 12'(12'h321 + i)) begin errs++; $display("FAIL arst_addr[%0d]: got %h exp %h", i, rd_q[rb+i], 12'(12'h321 + i)); end
    end
    for (int i = 0; i < 64 && qb + i < rise_q.size(); i++) begin
      vecs++; if (rise_q[qb+i] !== exp_rgb(12'(12'h321 + i), 3'd7)) begin errs++; $display("FAIL arst_rgb[%0d]: got %h exp %h", i, rise_q[qb+i], exp_rgb(12'(12'h321 + i), 3'd7)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bitplanes();
    test_clk_div();
    test_wrap();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
